wb_slave_select: RTL and testbench
==================================

WB_SLAVE_SELECT -- requirements
Module: wb_slave_select

Interface
REQ-001 SHALL have parameter WISHBONE_ADDRESSWIDTH, default 16: ADR_I width.
REQ-002 SHALL have parameter NUM_SLAVES, default 4, range 2..8: number of slave select lines.
REQ-003 SHALL have parameters DEC_MSB and DEC_LSB, defaults 14 and 12: the ADR_I decode field. FW = DEC_MSB-DEC_LSB+1.
REQ-004 SHALL have parameters MAP_BASE and MAP_LAST, each NUM_SLAVES*FW bits packed, slice i = slave i. Defaults: base {6,5,2,0}, last {6,5,4,0} (slave3..slave0).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535: watchdog limit.
REQ-006 CLK_I  in  1  single clock, all state on rising edge.
REQ-007 RST_I  in  1  reset, asynchronous, active-high.
REQ-008 ADR_I  in  WISHBONE_ADDRESSWIDTH  master address.
REQ-009 CYC_I, STB_I  in  1 each  master cycle and strobe.
REQ-010 ACK_I  in  NUM_SLAVES  per-slave acknowledge.
REQ-011 ACMP_O  out  NUM_SLAVES  registered one-hot slave select.
REQ-012 ACK_O  out  1  acknowledge returned to the master.
REQ-013 ERR_O  out  1  registered error pulse (unmapped access or timeout).
REQ-014 BUSY_O  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACTIVE and ERROR.
REQ-016 Hit rule: slave i hits when MAP_BASE[i] <= ADR_I[DEC_MSB:DEC_LSB] <= MAP_LAST[i]. On overlap the lowest index wins. No hit means unmapped.
REQ-017 IDLE, when CYC_I&STB_I is sampled:
- on a hit, latch the slave index, go to ACTIVE, and assert the ACMP_O bit on the next cycle (1-cycle decode latency);
- on a miss, go to ERROR.
REQ-018 ACTIVE: ACMP_O SHALL stay one-hot and stable, independent of further ADR_I changes.
REQ-019 ACK_O = (state==ACTIVE) & CYC_I & ACK_I[latched index], combinational. ACK_I bits of unselected slaves SHALL be ignored.
REQ-020 ACTIVE with ACK_O high: go to IDLE, and ACMP_O clears on the next edge.
REQ-021 ACTIVE with CYC_I low: abort to IDLE, ACMP_O clears on the next edge, and no ACK_O or ERR_O is produced.
REQ-022 ERROR: ERR_O is high for exactly one cycle, ACMP_O stays all-zero, and the next state is IDLE.
REQ-023 IDLE SHALL sample a new request on the first cycle after returning from any state, so back-to-back transfers are supported.
REQ-024 ACK_O SHALL never be asserted in IDLE or ERROR.
REQ-025 ERR_O and ACK_O SHALL never be high in the same cycle.

Reset
REQ-026 RST_I high SHALL immediately force state IDLE, ACMP_O=0, ERR_O=0, BUSY_O=0 and the watchdog counter to 0.
REQ-027 ACK_O SHALL be 0 during reset by construction.
REQ-028 A reset mid-transfer SHALL abandon the transfer with no ERR_O pulse.

Configuration
REQ-029 Macro WB_SLAVE_SELECT_TIMEOUT_EN defined: a 16-bit watchdog counter SHALL behave as follows.
- It clears on entry to ACTIVE and increments each ACTIVE cycle without ACK_O.
- When it reaches TIMEOUT_CYCLES the FSM goes to ERROR: ERR_O pulses on the next cycle and ACMP_O clears.
- If ACK_O and terminal count occur in the same cycle, ACK wins and there is no ERR_O.
REQ-030 Macro undefined: no counter logic exists, and ACTIVE waits indefinitely for ACK_I or a CYC_I drop.

Verification
REQ-031 Hit: ADR_I=0x3004, CYC/STB=1 -> cycle+1 ACMP_O=4'b0010, BUSY_O=1; ACK_I=4'b0010 -> ACK_O=1 same cycle; next cycle ACMP_O=0.
REQ-032 Unmapped: ADR_I=0x1000 -> cycle+1 ERR_O=1 for one cycle, ACMP_O=0 throughout, ACK_O=0.
REQ-033 Wrong-slave ACK: slave0 selected via ADR_I=0x0010 and ACK_I=4'b0100 -> ACK_O=0 and ACMP_O held at 4'b0001.
REQ-034 Abort: in ACTIVE for slave2, drop CYC_I -> next cycle ACMP_O=0, BUSY_O=0, no ERR_O.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=4): slave3 selected, no ACK -> ERR_O pulses exactly once after 4 ACTIVE cycles. With ACK_I on the 4th cycle -> ACK_O=1 and no ERR_O.
REQ-036 Reset mid-transfer: assert RST_I asynchronously while ACMP_O=4'b1000 -> ACMP_O=0 and BUSY_O=0 before the next clock edge. After release, ADR_I=0x5000 selects slave2 normally.

Source files
------------

// File: rtl/wb_slave_select.sv
// Wishbone address decoder: registered one-hot slave select, 1-cycle decode latency, ACK_O passes through combinationally.
// Holds the select until ACK or a CYC_I drop; define WB_SLAVE_SELECT_TIMEOUT_EN to add a watchdog that errors a stalled slave.
module wb_slave_select #(
    parameter int WISHBONE_ADDRESSWIDTH = 16,
    parameter int NUM_SLAVES            = 4,
    parameter int DEC_MSB               = 14,
    parameter int DEC_LSB               = 12,
    parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] MAP_BASE = {3'd6, 3'd5, 3'd2, 3'd0},
    parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] MAP_LAST = {3'd6, 3'd5, 3'd4, 3'd0},
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             CLK_I,
    input  logic                             RST_I,
    input  logic [WISHBONE_ADDRESSWIDTH-1:0] ADR_I,
    input  logic                             CYC_I,
    input  logic                             STB_I,
    input  logic [NUM_SLAVES-1:0]            ACK_I,
    output logic [NUM_SLAVES-1:0]            ACMP_O,
    output logic                             ACK_O,
    output logic                             ERR_O,
    output logic                             BUSY_O
);

    localparam int FW = DEC_MSB - DEC_LSB + 1;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [FW-1:0]   w_fld;
    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic            w_unused_adr;
`ifdef WB_SLAVE_SELECT_TIMEOUT_EN
    logic [15:0]     r_cnt;
`endif

    assign w_fld        = ADR_I[DEC_MSB:DEC_LSB];
    assign w_unused_adr = ^ADR_I;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((MAP_BASE[i*FW +: FW] <= w_fld) && (w_fld <= MAP_LAST[i*FW +: FW])) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    assign ACK_O  = (r_state == ST_ACTIVE) & CYC_I & ACK_I[r_idx];
    assign BUSY_O = (r_state != ST_IDLE);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            ACMP_O  <= '0;
            ERR_O   <= 1'b0;
`ifdef WB_SLAVE_SELECT_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            ERR_O <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (CYC_I && STB_I) begin
                        if (w_hit) begin
                            r_state <= ST_ACTIVE;
                            r_idx   <= w_idx;
                            ACMP_O  <= NUM_SLAVES'(1) << w_idx;
`ifdef WB_SLAVE_SELECT_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end else begin
                            r_state <= ST_ERROR;
                            ERR_O   <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // ACK beats abort and abort beats timeout; an abort is silent.
                    if (ACK_O || !CYC_I) begin
                        r_state <= ST_IDLE;
                        ACMP_O  <= '0;
                    end
`ifdef WB_SLAVE_SELECT_TIMEOUT_EN
                    else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= ST_ERROR;
                        ERR_O   <= 1'b1;
                        ACMP_O  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end
                ST_ERROR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    ACMP_O  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_select.sv
// Bench for wb_slave_select: directed vector table, hand-written timeout/reset sequences, randomized run against a transaction model.
module tb_wb_slave_select;

    localparam int TO = 4;
`ifdef WB_SLAVE_SELECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic        cyc, stb;
    logic [3:0]  ack_i;
    logic [3:0]  acmp;
    logic        ack_o, err_o, busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_slave_select #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .ADR_I (adr),
        .CYC_I (cyc),
        .STB_I (stb),
        .ACK_I (ack_i),
        .ACMP_O(acmp),
        .ACK_O (ack_o),
        .ERR_O (err_o),
        .BUSY_O(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic        cyc;
        logic        stb;
        logic [3:0]  ack;
        logic        e_ack;
        logic [3:0]  e_acmp;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: drive after the falling edge, check ACK_O before the rising edge, registered outputs just after it.
    task automatic cyc_step(input logic [15:0] a, input logic c, input logic s, input logic [3:0] k,
                            input logic e_ack, input logic [3:0] e_acmp, input logic e_err,
                            input logic e_busy, input string nm);
        @(negedge clk);
        adr = a; cyc = c; stb = s; ack_i = k;
        #1 chk({nm, ".ack"}, {15'd0, ack_o}, {15'd0, e_ack});
        @(posedge clk);
        #1;
        chk({nm, ".acmp"}, {12'd0, acmp}, {12'd0, e_acmp});
        chk({nm, ".err"},  {15'd0, err_o}, {15'd0, e_err});
        chk({nm, ".busy"}, {15'd0, busy_o}, {15'd0, e_busy});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; ack_i = '0; adr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference decode from the address map: slave i owns field values base[i]..last[i], lowest index first.
    function automatic int ref_decode(input logic [15:0] a);
        int base[4] = '{0, 2, 5, 6};
        int last[4] = '{0, 4, 5, 6};
        int f = (int'(a) >> 12) & 7;
        for (int i = 0; i < 4; i++)
            if (base[i] <= f && f <= last[i]) return i;
        return -1;
    endfunction

    int m_sel, m_age;
    bit m_err;

    initial begin
        rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0; ack_i = '0;

        tbl[0]  = '{16'h3004, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1};
        tbl[1]  = '{16'h0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{16'h1000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[3]  = '{16'h0000, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{16'h0010, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1};
        tbl[5]  = '{16'h3004, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0001, 1'b0, 1'b1};
        tbl[6]  = '{16'h7fff, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{16'h5000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1};
        tbl[8]  = '{16'h5000, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[10] = '{16'h6000, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{16'h6000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[12] = '{16'h6000, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{16'h0000, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.acmp", {12'd0, acmp}, 16'd0);
        chk("rst.err",  {15'd0, err_o}, 16'd0);
        chk("rst.busy", {15'd0, busy_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            cyc_step(tbl[i].adr, tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].e_ack,
                     tbl[i].e_acmp, tbl[i].e_err, tbl[i].e_busy, $sformatf("vec%0d", i));

        // Stalled slave3: watchdog fires after TO active cycles, or the select simply holds.
        cyc_step(16'h6000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, "to.sel");
        for (int i = 1; i < TO; i++)
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, $sformatf("to.wait%0d", i));
        if (TO_EN) begin
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, "to.fire");
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "to.after");
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "to.once");
        end else begin
            for (int i = 0; i < 20; i++)
                cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, "to.hold");
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, "to.ackend");
        end

        // ACK on the last allowed cycle wins over the terminal count.
        cyc_step(16'h6000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, "tc.sel");
        for (int i = 1; i < TO; i++)
            cyc_step(16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, "tc.wait");
        cyc_step(16'h0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, "tc.ack");
        cyc_step(16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "tc.noerr");

        // Asynchronous reset while slave3 is selected.
        cyc_step(16'h6000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, "ar.sel");
        @(negedge clk);
        ack_i = 4'b1000; adr = 16'h0000; stb = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar.acmp", {12'd0, acmp}, 16'd0);
        chk("ar.busy", {15'd0, busy_o}, 16'd0);
        chk("ar.err",  {15'd0, err_o}, 16'd0);
        chk("ar.ack",  {15'd0, ack_o}, 16'd0);
        @(posedge clk);
        #1 chk("ar.hold_err", {15'd0, err_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; ack_i = '0;
        cyc_step(16'h5000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, "ar.s2");
        cyc_step(16'h5000, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, "ar.s2ack");

        // Randomized traffic against the transaction model.
        do_reset();
        m_sel = -1; m_age = 0; m_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic e_ack;
            int   d;
            @(negedge clk);
            adr   = 16'($urandom);
            cyc   = ($urandom_range(0, 9) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            ack_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            e_ack = (m_sel >= 0) && cyc && ack_i[m_sel];
            #1 chk("rnd.ack", {15'd0, ack_o}, {15'd0, e_ack});
            if (m_err) begin
                m_err = 1'b0;
            end else if (m_sel >= 0) begin
                if (e_ack || !cyc) begin
                    m_sel = -1;
                end else if (TO_EN) begin
                    m_age++;
                    if (m_age == TO) begin
                        m_sel = -1;
                        m_err = 1'b1;
                    end
                end
            end else if (cyc && stb) begin
                d = ref_decode(adr);
                if (d >= 0) begin
                    m_sel = d;
                    m_age = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd.acmp", {12'd0, acmp}, (m_sel >= 0) ? 16'(1 << m_sel) : 16'd0);
            chk("rnd.err",  {15'd0, err_o}, {15'd0, m_err});
            chk("rnd.busy", {15'd0, busy_o}, {15'd0, (m_sel >= 0) || m_err});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
